uint32_transmitter: RTL and testbench
=====================================

# uint32_transmitter

Serialises 32-bit words onto the main UART transmit path by driving the `uart_tx` byte handshake: four bytes per word, most-significant byte first. It is the transmit-side counterpart of `uint32_receiver`. The top level uses it to return 32-bit values (configured lengths, counters, status words) to the host. A one-word holding register lets the top level queue the next word while the current one is still on the wire.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock (`main_clk` at top level).
- `reset`  in  1  synchronous, active-high reset.
- `data`  in  32  word to send; sampled only on an accepting edge.
- `enable`  in  1  send request; accepted on an edge where `enable && ready`.
- `ready`  out  1  combinational; `!hold_valid`, so a word can be accepted this cycle.
- `busy`  out  1  registered; high while a word is held or any byte of a word is outstanding.
- `done`  out  1  registered one-cycle pulse after the last byte of a word completes.
- `dropped`  out  1  registered one-cycle pulse when `enable && !ready`; that word is discarded.
- `uart_data`  out  8  byte to `uart_tx.data`.
- `uart_enable`  out  1  registered one-cycle start pulse to `uart_tx.enable`.
- `uart_ready`  in  1  `uart_tx.ready`; high when the transmitter is idle.

## Operation
- Registers:
  - `hold` (32 bits) and `hold_valid`;
  - `shift` (32 bits);
  - `idx` (3 bits, byte counter);
  - `csum` (8 bits, only with the macro);
  - `state`.
- Accept: on an edge with `enable && ready`, load `hold <= data` and set `hold_valid <= 1`.
- States:
  - IDLE: if `hold_valid`, load `shift <= hold`, clear `hold_valid`, set `idx <= 0` and `csum <= 0`, then go to SEND.
  - SEND: wait for `uart_ready == 1`. Then set `uart_enable <= 1` and `uart_data <= shift[31:24]` (or `csum` when on the checksum byte), set `csum <= csum ^ shift[31:24]`, and go to WAIT_LOW.
  - WAIT_LOW: wait for `uart_ready == 0`, confirming `uart_tx` took the byte, then go to WAIT_HIGH. There is no timeout.
  - WAIT_HIGH: wait for `uart_ready == 1`.
    - If `idx` equals the last index: pulse `done` and go to IDLE.
    - Otherwise: set `shift <= shift << 8`, `idx <= idx + 1`, and go to SEND.
- Last index: 3, or 4 with the checksum enabled.
- Handshake rules:
  - `uart_enable` is never high on two consecutive cycles.
  - `uart_enable` is never asserted while `uart_ready == 0`.
- Because the holding register refills during transmission, words go out back to back with no gaps beyond the IDLE→SEND turnaround.
- Simultaneous events:
  - A word may be accepted on the same edge that IDLE drains `hold`: `ready` is 0 that cycle, so the request is dropped.
  - The top level must therefore check `ready`.
- Reset, at any point including mid-word:
  - State returns to IDLE; `hold_valid`, `idx`, `csum` and `shift` clear.
  - `uart_enable`, `done`, `dropped` and `busy` go to 0; `uart_data` goes to 0; `ready` goes to 1.
  - The remaining bytes of the partial word are abandoned; the partial word is never resumed.

## Timing
- Reset values: `ready` = 1; `busy`, `done`, `dropped`, `uart_enable` = 0; `uart_data` = 8'd0.
- Accepting edge N with IDLE and `uart_ready` high:
  - N+1: IDLE loads `shift`.
  - N+2: SEND registers the first byte, so `uart_enable` is high in the cycle after edge N+2.
- `ready` returns high in the cycle after edge N+1.
- `busy` rises in the cycle after edge N. It falls in the same cycle `done` is high, provided nothing is held.
- `done` asserts one cycle after `uart_ready` returns high following the last byte.
- Per-byte cost is the `uart_tx` frame time plus 2 clocks (WAIT_HIGH→SEND, then registered enable).
- `dropped` asserts in the cycle after the rejecting edge.

## Configuration
- `UINT32_TX_CHECKSUM_EN`
  - Defined: a fifth byte is appended after each word, equal to the XOR of the four data bytes; `done` follows the fifth byte.
  - Undefined: exactly four bytes per word; the `csum` logic is removed.
  - Byte order and handshake are identical in both builds.

## Test plan
- Single word: reset, then `data` = 32'hDEADBEEF with a one-cycle `enable`, against a `uart_tx` model.
  - Required: bytes DE, AD, BE, EF (plus 22 with the macro); `uart_enable` asserted 2 clocks after accept; one `done` pulse; `busy` low afterwards.
- Back to back: accept 32'h01020304, then 32'hA5A55A5A while the first byte is in flight.
  - Required: 01 02 03 04 A5 A5 5A 5A in order; two `done` pulses; the second word is accepted with `ready` = 1.
- Overflow: while word 1 transmits and word 2 is held, request 32'hFFFFFFFF.
  - Required: `dropped` pulses once; `ready` = 0; FF bytes never appear on `uart_data`.
- Stall: the `uart_tx` model holds `uart_ready` low for 1000 cycles before the first byte.
  - Required: no `uart_enable` pulse during the stall; the sequence resumes correctly after `uart_ready` rises.
- Reset mid-word: assert `reset` for one cycle after the second byte of 32'h11223344.
  - Required: no further `uart_enable`; outputs at their reset values; the next word 32'h00000000 sends 00 00 00 00.
- Protocol check: assertions over every run that `uart_enable` never occurs with `uart_ready` = 0 and is never high on two consecutive cycles.

Source files
------------

// File: rtl/uint32_transmitter.sv
// Sends 32-bit words as four bytes, MSB first, through the uart_tx byte handshake.
// Optional fifth XOR checksum byte per word when UINT32_TX_CHECKSUM_EN is defined.
module uint32_transmitter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic        enable,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        dropped,
    output logic [7:0]  uart_data,
    output logic        uart_enable,
    input  logic        uart_ready
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StSend     = 2'd1;
    localparam logic [1:0] StWaitLow  = 2'd2;
    localparam logic [1:0] StWaitHigh = 2'd3;

`ifdef UINT32_TX_CHECKSUM_EN
    localparam logic [2:0] LastIdx = 3'd4;
`else
    localparam logic [2:0] LastIdx = 3'd3;
`endif

    logic [1:0]  state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  uart_data_q, uart_data_d;
    logic        uart_enable_q, uart_enable_d;
    logic        done_q, done_d;
    logic        dropped_q, dropped_d;
    logic        busy_q, busy_d;
`ifdef UINT32_TX_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_valid_d  = hold_valid_q;
        shift_d       = shift_q;
        idx_d         = idx_q;
        uart_data_d   = uart_data_q;
        uart_enable_d = 1'b0;
        done_d        = 1'b0;
        dropped_d     = enable && hold_valid_q;
`ifdef UINT32_TX_CHECKSUM_EN
        csum_d        = csum_q;
`endif

        // Accept and drain are exclusive: accept needs hold empty, drain needs it full.
        if (enable && !hold_valid_q) begin
            hold_d       = data;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (hold_valid_q) begin
                    shift_d      = hold_q;
                    hold_valid_d = 1'b0;
                    idx_d        = 3'd0;
`ifdef UINT32_TX_CHECKSUM_EN
                    csum_d       = 8'd0;
`endif
                    state_d      = StSend;
                end
            end
            StSend: begin
                if (uart_ready) begin
                    uart_enable_d = 1'b1;
                    uart_data_d   = shift_q[31:24];
`ifdef UINT32_TX_CHECKSUM_EN
                    if (idx_q == LastIdx) begin
                        uart_data_d = csum_q;
                    end
                    csum_d = csum_q ^ shift_q[31:24];
`endif
                    state_d = StWaitLow;
                end
            end
            StWaitLow: begin
                if (!uart_ready) begin
                    state_d = StWaitHigh;
                end
            end
            StWaitHigh: begin
                if (uart_ready) begin
                    if (idx_q == LastIdx) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        shift_d = {shift_q[23:0], 8'h00};
                        idx_d   = idx_q + 3'd1;
                        state_d = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = hold_valid_d || (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            hold_q        <= 32'd0;
            hold_valid_q  <= 1'b0;
            shift_q       <= 32'd0;
            idx_q         <= 3'd0;
            uart_data_q   <= 8'd0;
            uart_enable_q <= 1'b0;
            done_q        <= 1'b0;
            dropped_q     <= 1'b0;
            busy_q        <= 1'b0;
`ifdef UINT32_TX_CHECKSUM_EN
            csum_q        <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_valid_q  <= hold_valid_d;
            shift_q       <= shift_d;
            idx_q         <= idx_d;
            uart_data_q   <= uart_data_d;
            uart_enable_q <= uart_enable_d;
            done_q        <= done_d;
            dropped_q     <= dropped_d;
            busy_q        <= busy_d;
`ifdef UINT32_TX_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign ready       = !hold_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dropped     = dropped_q;
    assign uart_data   = uart_data_q;
    assign uart_enable = uart_enable_q;

endmodule

// File: tb/tb_uint32_transmitter.sv
// Directed bench for uint32_transmitter against a simple uart_tx byte-handshake model.
module tb_uint32_transmitter;

    localparam int unsigned Frame = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data = 32'd0;
    logic        enable = 1'b0;
    logic        ready;
    logic        busy;
    logic        done;
    logic        dropped;
    logic [7:0]  uart_data;
    logic        uart_enable;
    logic        uart_ready;

    logic        stall = 1'b0;
    int unsigned frame_cnt = 0;
    logic [7:0]  tx_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned enable_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned dropped_cnt = 0;
    int unsigned viol_cnt = 0;
    logic        prev_en = 1'b0;

    uint32_transmitter dut (
        .clk         (clk),
        .reset       (reset),
        .data        (data),
        .enable      (enable),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .dropped     (dropped),
        .uart_data   (uart_data),
        .uart_enable (uart_enable),
        .uart_ready  (uart_ready)
    );

    always #5 clk = ~clk;

    // uart_tx model: takes a byte on enable, then stays busy for Frame cycles.
    assign uart_ready = !stall && (frame_cnt == 0);

    always @(negedge clk) begin
        if (uart_enable) begin
            tx_q.push_back(uart_data);
            frame_cnt <= Frame;
        end else if (frame_cnt != 0) begin
            frame_cnt <= frame_cnt - 1;
        end
        if (uart_enable && !uart_ready) viol_cnt <= viol_cnt + 1;
        if (uart_enable && prev_en)     viol_cnt <= viol_cnt + 1;
        prev_en <= uart_enable;
        if (uart_enable) enable_cnt <= enable_cnt + 1;
        if (done)        done_cnt <= done_cnt + 1;
        if (dropped)     dropped_cnt <= dropped_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        data   = w;
        enable = 1'b1;
        tick();
        enable = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            if (!busy) break;
            tick();
        end
        check_eq("idle_timeout", {31'd0, busy}, 32'd0);
        tick();
    endtask

    task automatic wait_enable();
        for (int i = 0; i < 3000; i++) begin
            if (uart_enable) break;
            tick();
        end
        check_eq("enable_timeout", {31'd0, uart_enable}, 32'd1);
    endtask

    task automatic pop_byte(input string tag, input logic [7:0] exp);
        logic [31:0] obs;
        obs = (tx_q.size() > 0) ? {24'd0, tx_q.pop_front()} : 32'h0000_0100;
        check_eq(tag, obs, {24'd0, exp});
    endtask

    task automatic expect_word(input string tag, input logic [31:0] w);
        logic [7:0] cs;
        cs = 8'd0;
        for (int i = 0; i < 4; i++) begin
            pop_byte(tag, w[31 - 8 * i -: 8]);
            cs = cs ^ w[31 - 8 * i -: 8];
        end
`ifdef UINT32_TX_CHECKSUM_EN
        pop_byte({tag, "_csum"}, cs);
`else
        if (cs == 8'hff) n_checks = n_checks + 0;
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d0;
        int unsigned e0;
        int unsigned x0;

        repeat (3) tick();
        check_eq("rst_ready", {31'd0, ready}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_dropped", {31'd0, dropped}, 32'd0);
        check_eq("rst_uart_en", {31'd0, uart_enable}, 32'd0);
        check_eq("rst_uart_data", {24'd0, uart_data}, 32'd0);
        reset = 1'b0;
        tick();

        // Single word with latency checks
        d0 = done_cnt;
        send_word(32'hDEAD_BEEF);
        check_eq("acc_busy", {31'd0, busy}, 32'd1);
        check_eq("acc_ready", {31'd0, ready}, 32'd0);
        tick();
        check_eq("n1_ready", {31'd0, ready}, 32'd1);
        check_eq("n1_uart_en", {31'd0, uart_enable}, 32'd0);
        tick();
        check_eq("n2_uart_en", {31'd0, uart_enable}, 32'd1);
        check_eq("n2_uart_data", {24'd0, uart_data}, 32'h0000_00DE);
        for (int i = 0; i < 3000; i++) begin
            if (done) break;
            tick();
        end
        check_eq("single_done", {31'd0, done}, 32'd1);
        check_eq("single_busy_at_done", {31'd0, busy}, 32'd0);
        tick();
        check_eq("single_done_pulse", {31'd0, done}, 32'd0);
        wait_idle();
        expect_word("single", 32'hDEAD_BEEF);
        check_eq("single_done_cnt", done_cnt - d0, 32'd1);

        // Back to back
        d0 = done_cnt;
        send_word(32'h0102_0304);
        wait_enable();
        check_eq("b2b_ready", {31'd0, ready}, 32'd1);
        send_word(32'hA5A5_5A5A);
        wait_idle();
        expect_word("b2b_w1", 32'h0102_0304);
        expect_word("b2b_w2", 32'hA5A5_5A5A);
        check_eq("b2b_done_cnt", done_cnt - d0, 32'd2);

        // Overflow: third request while hold is full
        x0 = dropped_cnt;
        send_word(32'h0A0B_0C0D);
        wait_enable();
        send_word(32'h1A1B_1C1D);
        check_eq("ovf_ready", {31'd0, ready}, 32'd0);
        send_word(32'hFFFF_FFFF);
        check_eq("ovf_dropped", {31'd0, dropped}, 32'd1);
        tick();
        check_eq("ovf_dropped_pulse", {31'd0, dropped}, 32'd0);
        wait_idle();
        expect_word("ovf_w1", 32'h0A0B_0C0D);
        expect_word("ovf_w2", 32'h1A1B_1C1D);
        check_eq("ovf_no_extra", tx_q.size(), 32'd0);
        check_eq("ovf_dropped_cnt", dropped_cnt - x0, 32'd1);

        // Stall: uart_ready low for 1000 cycles
        stall = 1'b1;
        e0 = enable_cnt;
        send_word(32'hC3A5_7E18);
        repeat (1000) tick();
        check_eq("stall_no_enable", enable_cnt - e0, 32'd0);
        check_eq("stall_busy", {31'd0, busy}, 32'd1);
        stall = 1'b0;
        wait_idle();
        expect_word("stall", 32'hC3A5_7E18);

        // Reset after second byte
        e0 = enable_cnt;
        send_word(32'h1122_3344);
        for (int i = 0; i < 3000; i++) begin
            if (enable_cnt - e0 >= 2) break;
            tick();
        end
        check_eq("mid_two_bytes", enable_cnt - e0, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_ready", {31'd0, ready}, 32'd1);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_uart_en", {31'd0, uart_enable}, 32'd0);
        check_eq("mid_rst_uart_data", {24'd0, uart_data}, 32'd0);
        check_eq("mid_rst_done", {31'd0, done}, 32'd0);
        check_eq("mid_rst_dropped", {31'd0, dropped}, 32'd0);
        e0 = enable_cnt;
        repeat (40) tick();
        check_eq("mid_no_resume", enable_cnt - e0, 32'd0);
        check_eq("mid_partial_len", tx_q.size(), 32'd2);
        pop_byte("mid_b0", 8'h11);
        pop_byte("mid_b1", 8'h22);
        send_word(32'h0000_0000);
        wait_idle();
        expect_word("after_rst", 32'h0000_0000);

        check_eq("protocol_violations", viol_cnt, 32'd0);
        check_eq("queue_drained", tx_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
